// File: rtl/d_ff.sv
// Parameterised D register / delay line: d reaches q after STAGES enabled edges; sync active-high rst loads RESET_VALUE.
// en=0 freezes every stage together; building with D_FF_QN_EN adds the qn = ~q output.
module d_ff #(
    parameter int                 WIDTH       = 1,
    parameter int                 STAGES      = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
`ifdef D_FF_QN_EN
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
`else
    output logic [WIDTH-1:0] q
`endif
);

    generate
        if (WIDTH < 1 || STAGES < 1) begin : g_bad_param
            $error("d_ff: WIDTH and STAGES must both be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = d;
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];

`ifdef D_FF_QN_EN
    assign qn = ~stage_q[STAGES-1];
`endif

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: a 1-bit single-stage instance and an 8-bit three-stage instance (reset 8'hA5).
module tb_d_ff;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1, en1 = 1'b1, d1 = 1'b0;
    logic       rst8 = 1'b0, en8 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       q1;
    logic [7:0] q8;
`ifdef D_FF_QN_EN
    logic       qn1;
    logic [7:0] qn8;
`endif

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    d_ff #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) u_ff1 (
        .clk(clk), .rst(rst1), .en(en1), .d(d1),
`ifdef D_FF_QN_EN
        .qn(qn1),
`endif
        .q(q1)
    );

    d_ff #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_ff8 (
        .clk(clk), .rst(rst8), .en(en8), .d(d8),
`ifdef D_FF_QN_EN
        .qn(qn8),
`endif
        .q(q8)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the output is the value captured STAGES enabled edges ago, seeded with the reset value.
    logic       hist1 [$];
    logic [7:0] hist8 [$];
    bit         vld1 = 0, vld8 = 0;

    always @(posedge clk) begin
        logic       s_rst1, s_en1, s_d1, s_rst8, s_en8;
        logic [7:0] s_d8;
        s_rst1 = rst1; s_en1 = en1; s_d1 = d1;
        s_rst8 = rst8; s_en8 = en8; s_d8 = d8;
        if (s_rst1) begin
            hist1.delete();
            hist1.push_back(1'b0);
            vld1 = 1;
        end else if (s_en1 && vld1) begin
            hist1.push_back(s_d1);
            void'(hist1.pop_front());
        end
        if (s_rst8) begin
            hist8.delete();
            repeat (3) hist8.push_back(8'hA5);
            vld8 = 1;
        end else if (s_en8 && vld8) begin
            hist8.push_back(s_d8);
            void'(hist8.pop_front());
        end
        #1;
        if (vld1) begin
            chk("model_q1", {7'd0, q1}, {7'd0, hist1[0]});
`ifdef D_FF_QN_EN
            chk("model_qn1", {7'd0, qn1}, {7'd0, ~hist1[0]});
`endif
        end
        if (vld8) begin
            chk("model_q8", q8, hist8[0]);
`ifdef D_FF_QN_EN
            chk("model_qn8", qn8, ~hist8[0]);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1-bit single-stage instance
        tick;                                   chk("rst_q1", {7'd0, q1}, 8'h00);
`ifdef D_FF_QN_EN
        chk("rst_qn1", {7'd0, qn1}, 8'h01);
`endif
        rst1 = 0; d1 = 0; tick;                 chk("cap0", {7'd0, q1}, 8'h00);
        d1 = 1; tick;                           chk("cap1", {7'd0, q1}, 8'h01);
        d1 = 0; tick;                           chk("cap0b", {7'd0, q1}, 8'h00);
        d1 = 1; tick;                           chk("cap1b", {7'd0, q1}, 8'h01);
        en1 = 0;
        for (int i = 0; i < 3; i++) begin
            d1 = i[0]; tick;                    chk("hold", {7'd0, q1}, 8'h01);
        end
        en1 = 1; d1 = 0; tick;                  chk("resume0", {7'd0, q1}, 8'h00);
        d1 = 1; tick;                           chk("resume1", {7'd0, q1}, 8'h01);
        rst1 = 1; d1 = 1; tick;                 chk("rst_prio", {7'd0, q1}, 8'h00);
        rst1 = 0; tick;                         chk("post_rst", {7'd0, q1}, 8'h01);
        #5 rst1 = 1;
        #5 rst1 = 0;
        tick;                                   chk("rst_glitch", {7'd0, q1}, 8'h01);

        // 8-bit three-stage instance
        rst8 = 1; en8 = 1; d8 = 8'h77; tick;    chk("rst_q8", q8, 8'hA5);
`ifdef D_FF_QN_EN
        chk("rst_qn8", qn8, 8'h5A);
`endif
        rst8 = 0; d8 = 8'h01; tick;             chk("pipe_e1", q8, 8'hA5);
        d8 = 8'h02; tick;                       chk("pipe_e2", q8, 8'hA5);
        d8 = 8'h03; tick;                       chk("pipe_e3", q8, 8'h01);
        d8 = 8'h04; tick;                       chk("pipe_e4", q8, 8'h02);
        d8 = 8'h05; tick;                       chk("pipe_e5", q8, 8'h03);
        rst8 = 1; d8 = 8'h06; tick;             chk("mid_rst", q8, 8'hA5);
        rst8 = 0; d8 = 8'h10; tick;             chk("rel_e1", q8, 8'hA5);
        d8 = 8'h11; tick;                       chk("rel_e2", q8, 8'hA5);
        d8 = 8'h12; tick;                       chk("rel_e3", q8, 8'h10);
        en8 = 0; d8 = 8'hFF; tick;              chk("freeze1", q8, 8'h10);
        d8 = 8'hEE; tick;                       chk("freeze2", q8, 8'h10);
        en8 = 1; d8 = 8'h13; tick;              chk("unfreeze1", q8, 8'h11);
        d8 = 8'h14; tick;                       chk("unfreeze2", q8, 8'h12);
        tick;                                   chk("unfreeze3", q8, 8'h13);

        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
